// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the eight-digit display word from a scanned seven-segment bus.
// Define SEG_SCAN_DECODER_DP_EN to track decimal points; otherwise dp_out is tied low.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic [23:0] TIMEOUT_MAX   = 24'd1_000_000
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic [7:0]  sel,
    input  logic [7:0]  seg,
    output logic [31:0] disp_out,
    output logic [7:0]  dp_out,
    output logic        frame_done,
    output logic        frame_valid,
    output logic        code_err,
    output logic        sel_err
);
    localparam int unsigned       STAB_W    = 8;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
`ifdef SEG_SCAN_DECODER_DP_EN
    localparam int unsigned SEG_W = 8;
`else
    localparam int unsigned SEG_W = 7;
`endif
    localparam int unsigned WORD_W = 8 + SEG_W;

    typedef enum logic {SETTLE, HOLD} state_t;

    logic [SEG_W-1:0]  seg_in;
    logic [WORD_W-1:0] sync1, sync2, prev;
    state_t            state;
    logic [STAB_W-1:0] stab_cnt;
    logic              cap_vld;
    logic [7:0]        cap_sel;
    logic [SEG_W-1:0]  cap_seg;
    logic [7:0]        seen, seen_nxt;
    logic [23:0]       tmo_cnt, tmo_nxt;
    logic [2:0]        sel_idx;
    logic              sel_blank, sel_ok, dec_hit, digit_wr;
    logic [3:0]        dec_code;

`ifdef SEG_SCAN_DECODER_DP_EN
    assign seg_in = seg;
`else
    logic unused_dp;
    assign seg_in    = seg[6:0];
    assign unused_dp = seg[7];
    assign dp_out    = '0;
`endif

    // Segment pattern to display code; MSB flags a table hit.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = {1'b1, 4'd0};
            7'h79:   decode = {1'b1, 4'd1};
            7'h24:   decode = {1'b1, 4'd2};
            7'h30:   decode = {1'b1, 4'd3};
            7'h19:   decode = {1'b1, 4'd4};
            7'h12:   decode = {1'b1, 4'd5};
            7'h02:   decode = {1'b1, 4'd6};
            7'h78:   decode = {1'b1, 4'd7};
            7'h00:   decode = {1'b1, 4'd8};
            7'h10:   decode = {1'b1, 4'd9};
            7'h7F:   decode = {1'b1, 4'd10};
            7'h3F:   decode = {1'b1, 4'd11};
            7'h46:   decode = {1'b1, 4'd12};
            7'h09:   decode = {1'b1, 4'd13};
            7'h47:   decode = {1'b1, 4'd14};
            7'h0C:   decode = {1'b1, 4'd15};
            default: decode = 5'd0;
        endcase
    endfunction

    // Synchronizer, settle counter and slot capture.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            sync1    <= '1;
            sync2    <= '1;
            prev     <= '1;
            state    <= SETTLE;
            stab_cnt <= '0;
            cap_vld  <= 1'b0;
            cap_sel  <= 8'hFF;
            cap_seg  <= '1;
        end else begin
            sync1   <= {sel, seg_in};
            sync2   <= sync1;
            prev    <= sync2;
            cap_vld <= 1'b0;
            case (state)
                SETTLE: begin
                    if (sync2 != prev) begin
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        cap_vld <= 1'b1;
                        cap_sel <= sync2[WORD_W-1:SEG_W];
                        cap_seg <= sync2[SEG_W-1:0];
                        state   <= HOLD;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_W'(1);
                    end
                end
                HOLD: begin
                    if (sync2 != prev) begin
                        stab_cnt <= '0;
                        state    <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!cap_sel[i]) sel_idx = 3'(i);
        end
        sel_blank             = (cap_sel == 8'hFF);
        sel_ok                = $onehot(~cap_sel);
        {dec_hit, dec_code}   = decode(cap_seg[6:0]);
        digit_wr              = cap_vld && sel_ok && dec_hit;
        seen_nxt              = (seen == 8'hFF) ? 8'h00 : seen;
        if (digit_wr) seen_nxt[sel_idx] = 1'b1;
        tmo_nxt = (tmo_cnt == TIMEOUT_MAX) ? tmo_cnt : tmo_cnt + 24'd1;
    end

    // Digit store, frame tracking and timeout; a frame completion beats expiry.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            disp_out    <= 32'hAAAA_AAAA;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
            sel_err     <= 1'b0;
            seen        <= '0;
            tmo_cnt     <= '0;
`ifdef SEG_SCAN_DECODER_DP_EN
            dp_out      <= '0;
`endif
        end else begin
            code_err   <= cap_vld && sel_ok && !dec_hit;
            sel_err    <= cap_vld && !sel_ok && !sel_blank;
            seen       <= seen_nxt;
            frame_done <= (seen == 8'hFF);
            if (digit_wr) begin
                disp_out[{sel_idx, 2'b00} +: 4] <= dec_code;
`ifdef SEG_SCAN_DECODER_DP_EN
                dp_out[sel_idx] <= ~cap_seg[7];
`endif
            end
            if (seen == 8'hFF) begin
                tmo_cnt     <= '0;
                frame_valid <= 1'b1;
            end else begin
                tmo_cnt <= tmo_nxt;
                if (tmo_nxt == TIMEOUT_MAX) frame_valid <= 1'b0;
            end
        end
    end
endmodule
